// File: rtl/match_window_if.sv
// Result channel of match_window_counter: count, valid/ready handshake, overrun flag.
// Carries res_max as well when MATCH_WINDOW_MAX_EN is defined.
interface match_window_if #(
    parameter int unsigned CNT_W = 8
);
    logic [CNT_W-1:0] res_count;
    logic             res_valid;
    logic             res_ready;
    logic             res_overrun;
`ifdef MATCH_WINDOW_MAX_EN
    logic [CNT_W-1:0] res_max;
`endif

    modport master (
        input  res_ready,
        output res_count,
        output res_valid,
        output res_overrun
`ifdef MATCH_WINDOW_MAX_EN
        , output res_max
`endif
    );

    modport slave (
        output res_ready,
        input  res_count,
        input  res_valid,
        input  res_overrun
`ifdef MATCH_WINDOW_MAX_EN
        , input  res_max
`endif
    );
endinterface

// File: rtl/match_window_counter.sv
// Counts detector match pulses over windows of WINDOW enabled cycles and hands each count out
// over valid/ready. Optional MATCH_WINDOW_MAX_EN adds a running maximum of accepted results.
module match_window_counter #(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sync_clr,
    input  logic              b_in,
    output logic              win_busy,
    match_window_if.master    res
);
    localparam int unsigned     CYC_W    = $clog2(WINDOW);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(WINDOW - 1);

    if (WINDOW < 2 || WINDOW > 65535) begin : g_bad_window
        $error("match_window_counter: WINDOW must be in 2..65535");
    end

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CYC_W-1:0] cyc_cnt;
    logic [CYC_W-1:0] cyc_next;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_next;
    logic [CNT_W-1:0] acc_sum;
    logic             win_end;
    logic             load;
    logic             drop;

    // Saturating add of one pulse; clamps at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W+1)'(b);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Window sequencing; sync_clr beats window end, so a cleared final cycle yields no result.
    always_comb begin
        state_next = state;
        cyc_next   = cyc_cnt;
        acc_next   = acc;
        win_end    = 1'b0;
        acc_sum    = sat_add(acc, b_in);
        if (sync_clr) begin
            state_next = IDLE;
            cyc_next   = '0;
            acc_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state_next = COUNT;
                        cyc_next   = CYC_W'(1);
                        acc_next   = CNT_W'(b_in);
                    end
                end
                COUNT: begin
                    if (en) begin
                        if (cyc_cnt == LAST_CYC) begin
                            win_end    = 1'b1;
                            state_next = IDLE;
                            cyc_next   = '0;
                            acc_next   = '0;
                        end else begin
                            cyc_next = cyc_cnt + CYC_W'(1);
                            acc_next = acc_sum;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    cyc_next   = '0;
                    acc_next   = '0;
                end
            endcase
        end
    end

    // A finished window loads if the slot is empty or being drained this edge; otherwise it is lost.
    assign load = win_end && (!res.res_valid || res.res_ready);
    assign drop = win_end && res.res_valid && !res.res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt         <= '0;
            acc             <= '0;
            win_busy        <= 1'b0;
            res.res_count   <= '0;
            res.res_valid   <= 1'b0;
            res.res_overrun <= 1'b0;
        end else begin
            cyc_cnt  <= cyc_next;
            acc      <= acc_next;
            win_busy <= (state_next == COUNT);
            if (load) begin
                res.res_count <= acc_sum;
                res.res_valid <= 1'b1;
            end else if (res.res_valid && res.res_ready) begin
                res.res_valid <= 1'b0;
            end
            if (drop) begin
                res.res_overrun <= 1'b1;
            end
        end
    end

`ifdef MATCH_WINDOW_MAX_EN
    // Running maximum over accepted results only.
    always_ff @(posedge clk) begin
        if (rst) begin
            res.res_max <= '0;
        end else if (load && (acc_sum > res.res_max)) begin
            res.res_max <= acc_sum;
        end
    end
`endif
endmodule

// File: tb/tb_match_window_counter.sv
// Directed self-checking bench for match_window_counter (WINDOW=16, CNT_W=8 plus a CNT_W=3 copy).
module tb_match_window_counter;
    logic clk = 1'b0;
    logic rst;
    logic en;
    logic sync_clr;
    logic b_in;
    logic win_busy;
    logic win_busy3;
    int   vectors = 0;
    int   miscompares = 0;

    match_window_if #(.CNT_W(8)) bus ();
    match_window_if #(.CNT_W(3)) bus3 ();

    match_window_counter #(.WINDOW(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .b_in(b_in),
        .win_busy(win_busy), .res(bus)
    );

    match_window_counter #(.WINDOW(16), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .b_in(b_in),
        .win_busy(win_busy3), .res(bus3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic e, input logic b, input logic clr);
        en       = e;
        b_in     = b;
        sync_clr = clr;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; b_in = 1'b0; sync_clr = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; b_in = 1'b1; sync_clr = 1'b0; bus.res_ready = 1'b0;
        tick(); tick();
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", bus.res_valid); end
        vectors++; if (bus.res_count !== 8'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", bus.res_count); end
        vectors++; if (bus.res_overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", bus.res_overrun); end
        vectors++; if (win_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", win_busy); end
        rst = 1'b0;
        // reset mid-window must restart the window count from zero
        for (int i = 0; i < 5; i++) apply(1'b1, 1'b1, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++; if (win_busy !== 1'b0) begin miscompares++; $display("FAIL reset_mid_busy got %b want 0", win_busy); end
        for (int i = 0; i < 15; i++) apply(1'b1, 1'b1, 1'b0);
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mid_early got %b want 0", bus.res_valid); end
        apply(1'b1, 1'b1, 1'b0);
        vectors++; if (bus.res_count !== 8'd16) begin miscompares++; $display("FAIL reset_mid_count got %0d want 16", bus.res_count); end
    endtask

    task automatic test_full_ones();
        do_reset();
        bus.res_ready = 1'b1;
        for (int i = 0; i < 15; i++) apply(1'b1, 1'b1, 1'b0);
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL ones_early_valid got %b want 0", bus.res_valid); end
        vectors++; if (win_busy !== 1'b1) begin miscompares++; $display("FAIL ones_busy got %b want 1", win_busy); end
        apply(1'b1, 1'b1, 1'b0);
        vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL ones_valid got %b want 1", bus.res_valid); end
        vectors++; if (bus.res_count !== 8'd16) begin miscompares++; $display("FAIL ones_count got %0d want 16", bus.res_count); end
        vectors++; if (win_busy !== 1'b0) begin miscompares++; $display("FAIL ones_busy_end got %b want 0", win_busy); end
        vectors++; if (bus.res_overrun !== 1'b0) begin miscompares++; $display("FAIL ones_overrun got %b want 0", bus.res_overrun); end
        vectors++; if (bus3.res_count !== 3'd7) begin miscompares++; $display("FAIL sat_count got %0d want 7", bus3.res_count); end
        vectors++; if (bus3.res_valid !== 1'b1) begin miscompares++; $display("FAIL sat_valid got %b want 1", bus3.res_valid); end
        apply(1'b0, 1'b0, 1'b0);
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL ones_pulse got %b want 0", bus.res_valid); end
    endtask

    task automatic test_alternating();
        do_reset();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 16; i++) apply(1'b1, logic'((i % 2) == 0), 1'b0);
        vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL alt_valid got %b want 1", bus.res_valid); end
        vectors++; if (bus.res_count !== 8'd8) begin miscompares++; $display("FAIL alt_count got %0d want 8", bus.res_count); end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 1'b0);
            vectors++; if (bus.res_valid !== 1'b1 || bus.res_count !== 8'd8) begin
                miscompares++; $display("FAIL alt_hold valid=%b count=%0d want 1/8", bus.res_valid, bus.res_count);
            end
        end
        bus.res_ready = 1'b1;
        apply(1'b0, 1'b0, 1'b0);
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL alt_accept got %b want 0", bus.res_valid); end
        bus.res_ready = 1'b0;
    endtask

    task automatic test_overrun();
        do_reset();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 16; i++) apply(1'b1, 1'b1, 1'b0);
        vectors++; if (bus.res_overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_first got %b want 0", bus.res_overrun); end
        for (int i = 0; i < 16; i++) apply(1'b1, 1'b0, 1'b0);
        vectors++; if (bus.res_count !== 8'd16) begin miscompares++; $display("FAIL ovr_kept got %0d want 16", bus.res_count); end
        vectors++; if (bus.res_overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %b want 1", bus.res_overrun); end
        bus.res_ready = 1'b1;
        for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b0);
        vectors++; if (bus.res_overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky got %b want 1", bus.res_overrun); end
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_drain got %b want 0", bus.res_valid); end
        do_reset();
        vectors++; if (bus.res_overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_rst got %b want 0", bus.res_overrun); end
    endtask

    task automatic test_sync_clr();
        do_reset();
        bus.res_ready = 1'b1;
        for (int i = 0; i < 10; i++) apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b1);
        vectors++; if (win_busy !== 1'b0) begin miscompares++; $display("FAIL clr_busy got %b want 0", win_busy); end
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL clr_noresult got %b want 0", bus.res_valid); end
        for (int i = 0; i < 15; i++) apply(1'b1, 1'b0, 1'b0);
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL clr_early got %b want 0", bus.res_valid); end
        apply(1'b1, 1'b0, 1'b0);
        vectors++; if (bus.res_valid !== 1'b1) begin miscompares++; $display("FAIL clr_valid got %b want 1", bus.res_valid); end
        vectors++; if (bus.res_count !== 8'd0) begin miscompares++; $display("FAIL clr_count got %0d want 0", bus.res_count); end
        // sync_clr on the final cycle suppresses the result
        do_reset();
        for (int i = 0; i < 15; i++) apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b1, 1'b1);
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL clr_end_valid got %b want 0", bus.res_valid); end
        vectors++; if (win_busy !== 1'b0) begin miscompares++; $display("FAIL clr_end_busy got %b want 0", win_busy); end
    endtask

    task automatic test_pause();
        do_reset();
        bus.res_ready = 1'b1;
        for (int i = 0; i < 8; i++) apply(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) apply(1'b0, 1'b1, 1'b0);
        vectors++; if (win_busy !== 1'b1) begin miscompares++; $display("FAIL pause_busy got %b want 1", win_busy); end
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL pause_valid got %b want 0", bus.res_valid); end
        for (int i = 0; i < 7; i++) apply(1'b1, 1'b1, 1'b0);
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL pause_early got %b want 0", bus.res_valid); end
        apply(1'b1, 1'b1, 1'b0);
        vectors++; if (bus.res_count !== 8'd16 || bus.res_valid !== 1'b1) begin
            miscompares++; $display("FAIL pause_count count=%0d valid=%b want 16/1", bus.res_count, bus.res_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.res_ready = 1'b1;
        for (int i = 0; i < 16; i++) apply(1'b1, 1'b1, 1'b0);
        vectors++; if (bus.res_count !== 8'd16) begin miscompares++; $display("FAIL b2b_first got %0d want 16", bus.res_count); end
        apply(1'b1, 1'b1, 1'b0);
        vectors++; if (bus.res_valid !== 1'b0 || win_busy !== 1'b1) begin
            miscompares++; $display("FAIL b2b_nogap valid=%b busy=%b want 0/1", bus.res_valid, win_busy);
        end
        for (int i = 0; i < 15; i++) apply(1'b1, logic'(i < 2), 1'b0);
        vectors++; if (bus.res_count !== 8'd3 || bus.res_valid !== 1'b1) begin
            miscompares++; $display("FAIL b2b_second count=%0d valid=%b want 3/1", bus.res_count, bus.res_valid);
        end
    endtask

    task automatic test_load_on_transfer();
        do_reset();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 16; i++) apply(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) apply(1'b1, logic'(i < 5), 1'b0);
        bus.res_ready = 1'b1;
        apply(1'b1, 1'b0, 1'b0);
        vectors++; if (bus.res_count !== 8'd5 || bus.res_valid !== 1'b1) begin
            miscompares++; $display("FAIL lot_load count=%0d valid=%b want 5/1", bus.res_count, bus.res_valid);
        end
        vectors++; if (bus.res_overrun !== 1'b0) begin miscompares++; $display("FAIL lot_overrun got %b want 0", bus.res_overrun); end
        apply(1'b0, 1'b0, 1'b0);
        vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL lot_drain got %b want 0", bus.res_valid); end
    endtask

`ifdef MATCH_WINDOW_MAX_EN
    task automatic test_max();
        int ones [3];
        logic [7:0] exp_max [3];
        ones[0] = 5; ones[1] = 12; ones[2] = 3;
        exp_max[0] = 8'd5; exp_max[1] = 8'd12; exp_max[2] = 8'd12;
        do_reset();
        vectors++; if (bus.res_max !== 8'd0) begin miscompares++; $display("FAIL max_rst got %0d want 0", bus.res_max); end
        bus.res_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 16; i++) apply(1'b1, logic'(i < ones[w]), 1'b0);
            vectors++; if (bus.res_max !== exp_max[w]) begin
                miscompares++; $display("FAIL max_w%0d got %0d want %0d", w, bus.res_max, exp_max[w]);
            end
        end
        bus.res_ready = 1'b0;
        for (int i = 0; i < 16; i++) apply(1'b1, 1'b1, 1'b0);
        vectors++; if (bus.res_max !== 8'd12 || bus.res_overrun !== 1'b1) begin
            miscompares++; $display("FAIL max_drop max=%0d ovr=%b want 12/1", bus.res_max, bus.res_overrun);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; sync_clr = 1'b0; b_in = 1'b0;
        bus.res_ready  = 1'b0;
        bus3.res_ready = 1'b1;
        test_reset();
        test_full_ones();
        test_alternating();
        test_overrun();
        test_sync_clr();
        test_pause();
        test_back_to_back();
        test_load_on_transfer();
`ifdef MATCH_WINDOW_MAX_EN
        test_max();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/match_window_counter.md
Name: match_window_counter

Overview:
- Downstream consumer of the pair-match detector's 1-bit Mealy output.
- Counts match pulses over fixed windows of WINDOW enabled clock cycles.
- Presents each window's count to a downstream reader over a valid/ready handshake.
- Flags results lost because the reader stalled.

Parameters:
- WINDOW, 16, number of enabled cycles per window; legal range 2..65535.
- CNT_W, 8, width of the accumulator and result; the count saturates at 2^CNT_W-1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  count enable; when low the window is paused.
- sync_clr  input  1  aborts the current window; pulse.
- b_in  input  1  match pulse from the detector, sampled every enabled cycle.
- res_count  output  CNT_W  count for the completed window.
- res_valid  output  1  res_count holds an unconsumed result.
- res_ready  input  1  reader accepts the result.
- res_overrun  output  1  sticky: a result was dropped.
- win_busy  output  1  a window is in progress (state COUNT).

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, cyc_cnt=0, acc=0, res_count=0, res_valid=0, res_overrun=0, win_busy=0. Reset overrides every other input, including mid-window and mid-handshake.
- State IDLE:
  - en=1 -> COUNT.
  - This cycle is window cycle 0: cyc_cnt<=1, acc<=b_in.
- State COUNT:
  - en=1: cyc_cnt increments; acc<=sat(acc+b_in).
  - en=0: cyc_cnt and acc hold; the state stays COUNT.
- Window end, i.e. COUNT with en=1 and cyc_cnt==WINDOW-1:
  - Final value is sat(acc+b_in), so the last cycle's pulse is included.
  - cyc_cnt<=0, acc<=0, next state IDLE. A new window starts on the next enabled cycle with no gap cycle when en stays high.
- Saturation: acc and the final value clamp at 2^CNT_W-1. There is no wrap-around.
- sync_clr=1 (state COUNT or IDLE):
  - cyc_cnt<=0, acc<=0, state<=IDLE.
  - The output register and res_overrun are unaffected.
  - sync_clr coincident with window end: sync_clr wins and no result is produced.
- Result load, one cycle after the window-end edge, i.e. registered:
  - res_valid=0, or res_valid=1 with res_ready=1 on the same edge: res_count<=final, res_valid<=1. There is no overrun and res_valid does not drop.
  - res_valid=1 with res_ready=0: the new result is dropped, res_count holds its old value, res_overrun<=1.
- Handshake:
  - Transfer occurs on an edge where res_valid=1 and res_ready=1; res_valid<=0 unless a load happens on the same edge.
  - res_count is stable while res_valid=1 and res_ready=0.
  - res_ready while res_valid=0 has no effect.
- res_overrun clears only on rst.
- win_busy = (state==COUNT), registered.
- With WINDOW=1 disallowed, the IDLE->COUNT entry cycle can never be the window end.

Optional Feature:
- Macro: MATCH_WINDOW_MAX_EN.
- Defined:
  - Adds output res_max [CNT_W], reset 0.
  - On each accepted result load, res_max<=max(res_max, loaded value).
  - Dropped (overrun) results do not update res_max.
  - sync_clr does not affect res_max.
- Undefined: the port and register are absent; all other behaviour is identical.

Test Plan:
- rst, en=1, b_in=1 for 16 cycles, res_ready=1 -> res_valid pulses once with res_count=16; res_overrun=0.
- en=1, b_in alternates 1,0 over 16 cycles, res_ready=0 -> res_valid=1, res_count=8 held stable. Then res_ready=1 for one cycle -> res_valid=0 on the next edge.
- Two consecutive 16-cycle windows with res_ready=0 throughout -> the first count is retained, the second is dropped, res_overrun=1 until rst.
- CNT_W=3, WINDOW=16, b_in=1 continuously -> res_count=7 (saturated).
- b_in=1 for 10 cycles, then sync_clr=1, then 16 cycles of b_in=0 -> result 0; no result was produced at the cleared window.
- en low for 5 cycles mid-window (after 8 counted ones) -> cycles paused; completing 8 more enabled cycles with b_in=1 -> res_count=16.
- MATCH_WINDOW_MAX_EN defined, results 5, 12, 3 accepted in order -> res_max=12.
